// File: rtl/mypackage.sv
// Shared synth-voice types: oscillator sample format and envelope generator
// defaults and state encoding.
package mypackage;

  localparam int AMPLITUDE_BITS = 12;
  typedef logic signed [AMPLITUDE_BITS-1:0] amplitude_t;

  localparam int ENV_BITS_DEFAULT = 16;

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

endpackage

// File: rtl/envelope_gen_amp_scale.sv
// Signed oscillator sample times unsigned envelope level, scaled back to the
// sample width by an arithmetic shift of ENV_BITS (rounds toward -infinity).
module amp_scale
  import mypackage::*;
#(
  parameter int ENV_BITS = ENV_BITS_DEFAULT
) (
  input  amplitude_t          din,
  input  logic [ENV_BITS-1:0] level,
  output amplitude_t          scaled
);

  localparam int PROD_BITS = AMPLITUDE_BITS + ENV_BITS;

  // |din * level| < 2^(PROD_BITS-1), so the product never overflows.
  logic signed [PROD_BITS-1:0] din_ext;
  logic signed [PROD_BITS-1:0] level_ext;
  logic signed [PROD_BITS-1:0] product;

  assign din_ext   = PROD_BITS'(din);
  assign level_ext = $signed({{AMPLITUDE_BITS{1'b0}}, level});
  assign product   = din_ext * level_ext;
  assign scaled    = AMPLITUDE_BITS'(product >>> ENV_BITS);

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope generator: five-state FSM stepping an unsigned level on each
// sample strobe, and a registered level-scaled copy of the oscillator sample.
module envelope_gen
  import mypackage::*;
#(
  parameter int ENV_BITS = ENV_BITS_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                gate,
  input  logic [ENV_BITS-1:0] attack_rate,
  input  logic [ENV_BITS-1:0] decay_rate,
  input  logic [ENV_BITS-1:0] release_rate,
  input  logic [ENV_BITS-1:0] sustain_level,
  input  amplitude_t          din,
  output amplitude_t          dout,
  output logic [ENV_BITS-1:0] env_level,
  output logic                busy
);

  localparam logic [ENV_BITS-1:0] LEVEL_MAX = '1;

  env_state_t          state;
  env_state_t          next_state;
  logic [ENV_BITS-1:0] level;
  logic [ENV_BITS-1:0] next_level;
  logic                prev_gate;
  amplitude_t          dout_reg;
  amplitude_t          scaled;

  logic                rise;
  logic [ENV_BITS:0]   attack_sum;
  logic [ENV_BITS:0]   decay_floor;
  logic                attack_done;
  logic                decay_done;
  logic                release_done;

  amp_scale #(.ENV_BITS(ENV_BITS)) u_amp_scale (
    .din    (din),
    .level  (level),
    .scaled (scaled)
  );

  // Completion tests run in ENV_BITS+1 bits so no sum or difference can wrap.
  assign rise         = gate & ~prev_gate;
  assign attack_sum   = {1'b0, level} + {1'b0, attack_rate};
  assign decay_floor  = {1'b0, sustain_level} + {1'b0, decay_rate};
  assign attack_done  = (attack_rate == '0) || (attack_sum >= {1'b0, LEVEL_MAX});
  assign decay_done   = (decay_rate == '0) || (sustain_level >= level) ||
                        (decay_floor >= {1'b0, level});
  assign release_done = (release_rate == '0) || (release_rate >= level);

  always_comb begin
    next_state = state;
    next_level = level;
    case (state)
      ENV_IDLE: begin
        next_level = '0;
        if (rise) next_state = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (!gate) begin
          next_state = ENV_RELEASE;
        end else if (attack_done) begin
          next_level = LEVEL_MAX;
          next_state = ENV_DECAY;
        end else begin
          next_level = attack_sum[ENV_BITS-1:0];
        end
      end
      ENV_DECAY: begin
        if (!gate) begin
          next_state = ENV_RELEASE;
        end else if (decay_done) begin
          next_level = sustain_level;
          next_state = ENV_SUSTAIN;
        end else begin
          next_level = level - decay_rate;
        end
      end
      ENV_SUSTAIN: begin
        if (!gate) next_state = ENV_RELEASE;
        else       next_level = sustain_level;
      end
      ENV_RELEASE: begin
        // A retrigger resumes attack from wherever the level currently is.
        if (rise) begin
          next_state = ENV_ATTACK;
        end else if (release_done) begin
          next_level = '0;
          next_state = ENV_IDLE;
        end else begin
          next_level = level - release_rate;
        end
      end
      default: begin
        next_state = ENV_IDLE;
        next_level = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ENV_IDLE;
      level     <= '0;
      prev_gate <= 1'b0;
      dout_reg  <= '0;
    end else if (enable) begin
      state     <= next_state;
      level     <= next_level;
      prev_gate <= gate;
      dout_reg  <= scaled;
    end
  end

  assign dout      = dout_reg;
  assign env_level = level;
  assign busy      = (state != ENV_IDLE);

endmodule

// File: doc/envelope_gen.md
ENVELOPE_GEN -- requirements
Module: envelope_gen

Interface
REQ-001 SHALL have parameter ENV_BITS, default 16, envelope level and rate width.
REQ-002 SHALL have port clock  input  1  system clock; one clock domain only.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  sample strobe; all state, level and output updates occur only on enabled clock edges.
REQ-005 SHALL have port gate  input  1  note-on level (high = key held).
REQ-006 SHALL have ports attack_rate, decay_rate, release_rate  input  ENV_BITS each  per-sample level step.
REQ-007 SHALL have port sustain_level  input  ENV_BITS  sustain target.
REQ-008 SHALL have port din  input  amplitude  oscillator sample, signed two's complement, AMPLITUDE_BITS wide.
REQ-009 SHALL have port dout  output  amplitude  scaled sample for the pdm stage.
REQ-010 SHALL have port env_level  output  ENV_BITS  current envelope level, unsigned.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-013 SHALL detect gate rising edge by comparing gate with its value at the previous enabled edge.
REQ-014 IDLE: gate rise -> ATTACK; level held at 0.
REQ-015 ATTACK: level += attack_rate, saturating at MAX = 2^ENV_BITS-1; on reaching MAX -> DECAY.
REQ-016 DECAY: level -= decay_rate, floored at sustain_level; on reaching sustain_level -> SUSTAIN.
REQ-017 SUSTAIN: level = sustain_level each enabled cycle (tracks live changes).
REQ-018 ATTACK, DECAY or SUSTAIN with gate low -> RELEASE; gate-low check has priority over the step-completion transition.
REQ-019 RELEASE: level -= release_rate, floored at 0; on reaching 0 -> IDLE.
REQ-020 RELEASE with gate rise -> ATTACK, starting from the current level (no reset to 0).
REQ-021 A rate of 0 SHALL mean an instant step: level jumps directly to that phase's target in one enabled cycle.
REQ-022 If sustain_level exceeds the current level in DECAY, level SHALL be set to sustain_level and the FSM SHALL go to SUSTAIN.
REQ-023 Arithmetic SHALL use ENV_BITS+1-bit intermediates; no wrap-around permitted.
REQ-024 dout SHALL equal (din * level) arithmetically shifted right by ENV_BITS, using the level held before this edge's update, registered with 1 enabled-cycle latency.
REQ-025 Without enable, all registers SHALL hold their values.

Reset
REQ-026 On reset: state = IDLE, level = 0, env_level = 0, dout = 0, busy = 0, previous-gate register = 0.
REQ-027 Reset SHALL override enable and abort any phase mid-operation; the cycle after reset deasserts, a held-high gate SHALL count as a rising edge.

Structure
REQ-028 The amplitude typedef and AMPLITUDE_BITS SHALL come from mypackage; ENV_BITS default and the envelope state enum SHALL be added to mypackage.
REQ-029 The signed multiply-and-shift SHALL be one sub-module, amp_scale; the FSM and level logic SHALL stay in envelope_gen.

Verification (ENV_BITS=16, enable held high)
REQ-030 Reset with gate=1 and din=2047 -> dout=0, env_level=0, busy=0 while reset is high.
REQ-031 gate 0->1, attack_rate=16384 -> env_level 16384, 32768, 49152, 65535, then state DECAY.
REQ-032 From 65535 with decay_rate=10000 and sustain_level=40000 -> 55535, 45535, 40000, then SUSTAIN held.
REQ-033 gate->0 at 40000 with release_rate=20000 -> 20000, 0, then IDLE and busy=0.
REQ-034 din=2047 at level 65535 -> dout=2046; din=-2048 at level 32768 -> dout=-1024.
REQ-035 gate re-rises in RELEASE at 20000 with attack_rate=16384 -> 36384 in ATTACK; reset asserted mid-ATTACK -> all outputs 0 on the next edge.
